// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
// Builds framed commands (SYNC, CMD, LEN, LEN payload bytes[, checksum]) out of
// the UART receiver byte stream. It emits one decoded command per good frame
// and pulses an error flag for a bad length, a timeout or a bad checksum.
// Build option: define CMD_CHECKSUM_EN to require a trailing XOR checksum byte
// (CMD ^ LEN ^ payload) and to enable err_checksum. Without it, err_checksum is 0.
// TIMEOUT_CYCLES must be at least 2.
module uart_cmd_parser #(
  parameter int          MAX_PAYLOAD    = 4,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 400_000,
  localparam int         LEN_W          = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_data_valid,
  output logic [7:0]               cmd_code,
  output logic [LEN_W-1:0]         cmd_len,
  output logic [8*MAX_PAYLOAD-1:0] cmd_payload,
  output logic                     cmd_valid,
  output logic                     err_len,
  output logic                     err_timeout,
  output logic                     err_checksum
);

  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      MAX_LEN = 8'(MAX_PAYLOAD);

`ifdef CMD_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, CMD, LEN, PAYLOAD, CHK} state_t;
`else
  typedef enum logic [2:0] {IDLE, CMD, LEN, PAYLOAD} state_t;
`endif

  state_t                   state_reg;
  logic [7:0]               code_reg;
  logic [LEN_W-1:0]         len_reg;
  logic [LEN_W-1:0]         idx_reg;
  logic [8*MAX_PAYLOAD-1:0] payload_reg;
  logic [TO_W-1:0]          to_cnt_reg;
  logic [8*MAX_PAYLOAD-1:0] payload_ins;
  logic                     last_byte;
`ifdef CMD_CHECKSUM_EN
  logic [7:0]               chk_reg;
`else
  assign err_checksum = 1'b0;
`endif

  // Staging image with the incoming byte dropped into the slot at idx_reg.
  for (genvar gi = 0; gi < MAX_PAYLOAD; gi++) begin : g_lane
    assign payload_ins[8*gi +: 8] = (idx_reg == LEN_W'(gi)) ? rx_data : payload_reg[8*gi +: 8];
  end

  // The current payload byte is the last one that LEN announced.
  assign last_byte = (idx_reg + LEN_W'(1)) == len_reg;

  // Frame FSM: consumes bytes on strobes, times out on silence, and registers all outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      code_reg     <= '0;
      len_reg      <= '0;
      idx_reg      <= '0;
      payload_reg  <= '0;
      to_cnt_reg   <= '0;
      cmd_code     <= '0;
      cmd_len      <= '0;
      cmd_payload  <= '0;
      cmd_valid    <= 1'b0;
      err_len      <= 1'b0;
      err_timeout  <= 1'b0;
`ifdef CMD_CHECKSUM_EN
      chk_reg      <= '0;
      err_checksum <= 1'b0;
`endif
    end else begin
      cmd_valid   <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
`ifdef CMD_CHECKSUM_EN
      err_checksum <= 1'b0;
`endif
      if (rx_data_valid) begin
        // A byte arriving on the expiry cycle wins over the timeout.
        to_cnt_reg <= '0;
        case (state_reg)
          IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              state_reg   <= CMD;
              payload_reg <= '0;
`ifdef CMD_CHECKSUM_EN
              chk_reg     <= '0;
`endif
            end
          end
          CMD: begin
            code_reg  <= rx_data;
            state_reg <= LEN;
`ifdef CMD_CHECKSUM_EN
            chk_reg   <= chk_reg ^ rx_data;
`endif
          end
          LEN: begin
`ifdef CMD_CHECKSUM_EN
            chk_reg <= chk_reg ^ rx_data;
`endif
            if (rx_data > MAX_LEN) begin
              err_len   <= 1'b1;
              state_reg <= IDLE;
            end else if (rx_data == 8'd0) begin
              len_reg <= '0;
`ifdef CMD_CHECKSUM_EN
              state_reg <= CHK;
`else
              cmd_code    <= code_reg;
              cmd_len     <= '0;
              cmd_payload <= payload_reg;
              cmd_valid   <= 1'b1;
              state_reg   <= IDLE;
`endif
            end else begin
              len_reg   <= rx_data[LEN_W-1:0];
              idx_reg   <= '0;
              state_reg <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            // SYNC_BYTE is plain data here; only the length ends the payload.
            payload_reg <= payload_ins;
            idx_reg     <= idx_reg + LEN_W'(1);
`ifdef CMD_CHECKSUM_EN
            chk_reg     <= chk_reg ^ rx_data;
            if (last_byte) state_reg <= CHK;
`else
            if (last_byte) begin
              cmd_code    <= code_reg;
              cmd_len     <= len_reg;
              cmd_payload <= payload_ins;
              cmd_valid   <= 1'b1;
              state_reg   <= IDLE;
            end
`endif
          end
`ifdef CMD_CHECKSUM_EN
          CHK: begin
            if (rx_data == chk_reg) begin
              cmd_code    <= code_reg;
              cmd_len     <= len_reg;
              cmd_payload <= payload_reg;
              cmd_valid   <= 1'b1;
            end else begin
              err_checksum <= 1'b1;
            end
            state_reg <= IDLE;
          end
`endif
          default: state_reg <= IDLE;
        endcase
      end else if (state_reg == IDLE) begin
        to_cnt_reg <= '0;
      end else if (to_cnt_reg == TO_LAST) begin
        // Saturate at expiry. Returning to IDLE clears the counter on the next cycle.
        err_timeout <= 1'b1;
        state_reg   <= IDLE;
      end else begin
        to_cnt_reg <= to_cnt_reg + TO_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser
// Self-checking bench for uart_cmd_parser. It applies the directed frames first,
// then a stream of random frames. Each frame is built from its contents, so the
// expected outcome (command fields or error pulse) is known when the frame is built.
// Honours CMD_CHECKSUM_EN the same way as the design.
`timescale 1ns/1ps
module tb_uart_cmd_parser;
  localparam int MAXP = 4;
  localparam int TO   = 20;
  localparam int LW   = $clog2(MAXP + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_data_valid = 1'b0;
  logic [7:0]        cmd_code;
  logic [LW-1:0]     cmd_len;
  logic [8*MAXP-1:0] cmd_payload;
  logic              cmd_valid, err_len, err_timeout, err_checksum;
  logic [3:0]        pulses;

  int vectors = 0;
  int miscompares = 0;

  // Last good command as the outputs should present it.
  logic [7:0]        m_code;
  logic [LW-1:0]     m_len;
  logic [8*MAXP-1:0] m_payload;
  // Frame queued for sending, with its expected result.
  logic [7:0]        frame_q[$];
  logic [3:0]        frame_exp;
  logic [7:0]        p_code;
  logic [LW-1:0]     p_len;
  logic [8*MAXP-1:0] p_payload;

  localparam logic [3:0] P_CMD = 4'b1000, P_LEN = 4'b0100, P_TMO = 4'b0010, P_CHK = 4'b0001;

  uart_cmd_parser #(.MAX_PAYLOAD(MAXP), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .cmd_code(cmd_code), .cmd_len(cmd_len), .cmd_payload(cmd_payload),
    .cmd_valid(cmd_valid), .err_len(err_len), .err_timeout(err_timeout),
    .err_checksum(err_checksum)
  );

  assign pulses = {cmd_valid, err_len, err_timeout, err_checksum};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] exp_p);
    check({tag, "/pulse"},   64'(pulses),      64'(exp_p));
    check({tag, "/code"},    64'(cmd_code),    64'(m_code));
    check({tag, "/len"},     64'(cmd_len),     64'(m_len));
    check({tag, "/payload"}, 64'(cmd_payload), 64'(m_payload));
  endtask

  // Put one strobe d cycles after the previous one (d >= 2) and check the cycle that follows it.
  task automatic send_byte(input logic [7:0] b, input int d, input logic [3:0] exp_p);
    for (int k = 0; k < d - 1; k++) begin
      @(negedge clk);
      check("idle/pulse", 64'(pulses), 64'(0));
    end
    rx_data = b;
    rx_data_valid = 1'b1;
    @(negedge clk);
    rx_data_valid = 1'b0;
    rx_data = 8'($urandom);
    check_all("byte", exp_p);
  endtask

  task automatic send_frame(input int dmin, input int dmax);
    for (int i = 0; i < frame_q.size(); i++) begin
      if (i == frame_q.size() - 1) begin
        if (frame_exp[3]) begin
          m_code = p_code; m_len = p_len; m_payload = p_payload;
        end
        send_byte(frame_q[i], $urandom_range(dmax, dmin), frame_exp);
      end else begin
        send_byte(frame_q[i], $urandom_range(dmax, dmin), 4'b0000);
      end
    end
  endtask

  // After the last strobe, err_timeout is expected exactly in cycle TO+1 counted from that strobe.
  task automatic wait_timeout();
    for (int k = 1; k <= TO + 1; k++) begin
      @(negedge clk);
      check("tmo/pulse", 64'(pulses), 64'((k == TO) ? P_TMO : 4'b0000));
    end
  endtask

  task automatic build_good(input logic [7:0] code, input int len, input logic [8*MAXP-1:0] pl,
                            input bit bad_chk);
    logic [7:0] x;
    frame_q = {};
    frame_q.push_back(8'hA5);
    frame_q.push_back(code);
    frame_q.push_back(8'(len));
    x = code ^ 8'(len);
    p_payload = '0;
    for (int i = 0; i < len; i++) begin
      frame_q.push_back(pl[8*i +: 8]);
      x ^= pl[8*i +: 8];
      p_payload[8*i +: 8] = pl[8*i +: 8];
    end
    p_code = code;
    p_len  = LW'(len);
`ifdef CMD_CHECKSUM_EN
    frame_q.push_back(bad_chk ? (x ^ 8'($urandom_range(255, 1))) : x);
    frame_exp = bad_chk ? P_CHK : P_CMD;
`else
    frame_exp = P_CMD;
`endif
  endtask

  initial begin
    m_code = '0; m_len = '0; m_payload = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_all("reset", 4'b0000);

    // Basic two-byte frame.
    build_good(8'h10, 2, 32'h0000_1234, 1'b0);
    send_frame(2, 4);
`ifdef CMD_CHECKSUM_EN
    // Same frame with a zero checksum byte: error, fields kept.
    build_good(8'h10, 2, 32'h0000_1234, 1'b0);
    frame_q[frame_q.size() - 1] = 8'h00;
    frame_exp = P_CHK;
    send_frame(2, 4);
`endif
    // Oversized LEN, then a zero-length frame.
    frame_q = {8'hA5, 8'h10, 8'h05};
    frame_exp = P_LEN;
    send_frame(2, 4);
    build_good(8'h20, 0, '0, 1'b0);
    send_frame(2, 4);
    // Leading garbage, then SYNC used as payload data.
    frame_q = {8'h00, 8'hFF, 8'h3C};
    frame_exp = 4'b0000;
    send_frame(2, 4);
    build_good(8'h11, 1, 32'h0000_00A5, 1'b0);
    send_frame(2, 4);
    // Silence inside a frame.
    frame_q = {8'hA5, 8'h10};
    frame_exp = 4'b0000;
    send_frame(2, 3);
    wait_timeout();
    // Every gap is exactly the expiry cycle: the bytes win.
    build_good(8'h10, 1, 32'h0000_0055, 1'b0);
    send_frame(TO, TO);
    build_good(8'h30, 1, 32'h0000_007E, 1'b0);
    send_frame(2, 4);
    // Reset in the middle of a frame.
    frame_q = {8'hA5, 8'h10, 8'h01};
    frame_exp = 4'b0000;
    send_frame(2, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_code = '0; m_len = '0; m_payload = '0;
    check_all("rst_mid", 4'b0000);
    for (int k = 0; k < TO + 4; k++) begin
      @(negedge clk);
      check("post_rst/pulse", 64'(pulses), 64'(0));
    end
    build_good(8'h42, 3, 32'h00C3_B2A1, 1'b0);
    send_frame(2, 4);
    $display("directed frames done");

    // Random frames.
    for (int f = 0; f < 120; f++) begin
      int mode;
      int k;
      logic [7:0] g;
      mode = $urandom_range(4, 0);
      case (mode)
        0, 1: begin
          build_good(8'($urandom), $urandom_range(MAXP, 0), 32'($urandom), mode == 1);
          send_frame(2, TO);
        end
        2: begin
          frame_q = {8'hA5, 8'($urandom), 8'($urandom_range(255, MAXP + 1))};
          frame_exp = P_LEN;
          send_frame(2, TO);
        end
        3: begin
          frame_q = {};
          for (int i = 0; i < $urandom_range(3, 1); i++) begin
            g = 8'($urandom);
            if (g == 8'hA5) g = 8'h5A;
            frame_q.push_back(g);
          end
          frame_exp = 4'b0000;
          send_frame(2, TO);
        end
        default: begin
          build_good(8'($urandom), $urandom_range(MAXP, 0), 32'($urandom), 1'b0);
          k = $urandom_range(frame_q.size() - 1, 1);
          frame_q = frame_q[0:k-1];
          frame_exp = 4'b0000;
          send_frame(2, TO);
          wait_timeout();
        end
      endcase
      $display("frame %0d mode %0d bytes %0d", f, mode, frame_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Sits directly downstream of the UART receiver. Consumes its byte stream (rx_data plus a one-cycle rx_data_valid pulse, no backpressure) and assembles framed commands for the delay-unit control logic.
- Frame format: SYNC, CMD, LEN, LEN payload bytes, then an optional XOR checksum byte.
- Emits one decoded command per good frame.
- Flags length, timeout and checksum errors, then resynchronises on the next SYNC byte.

Parameters:
- MAX_PAYLOAD, 4: maximum payload bytes per frame (at least 1).
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CYCLES, 400_000: maximum clk cycles between bytes inside a frame (4 ms at 100 MHz).
- Derived LEN_W = $clog2(MAX_PAYLOAD+1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  received byte; valid only while rx_data_valid=1
- rx_data_valid  in  1  one-cycle strobe per byte; never asserted on consecutive cycles
- cmd_code  out  8  command byte of the last good frame
- cmd_len  out  LEN_W  payload length of the last good frame
- cmd_payload  out  8*MAX_PAYLOAD  payload; first byte in [7:0], unused bytes zero
- cmd_valid  out  1  one-cycle pulse when a good frame completes
- err_len  out  1  one-cycle pulse: LEN > MAX_PAYLOAD
- err_timeout  out  1  one-cycle pulse: inter-byte timeout inside a frame
- err_checksum  out  1  one-cycle pulse: checksum mismatch (only with the feature enabled)

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0, payload staging register 0, running checksum 0.
- A byte is consumed only in a cycle where rx_data_valid=1. All state transitions happen on that edge.
- IDLE:
  - Byte == SYNC_BYTE -> CMD; clear staging register and checksum.
  - Any other byte is discarded silently (no error).
- CMD: store the byte, checksum ^= byte -> LEN.
- LEN (checksum ^= byte):
  - Byte > MAX_PAYLOAD -> err_len pulse, go to IDLE.
  - Byte == 0 -> CHK if CMD_CHECKSUM_EN is defined, otherwise complete the frame.
  - Otherwise -> PAYLOAD with byte index 0.
- PAYLOAD:
  - Write the byte into slot [8*idx +: 8]; checksum ^= byte; idx++.
  - After byte LEN-1 -> CHK (feature on) or complete the frame (feature off).
  - A SYNC_BYTE value here is ordinary data and does not restart the frame.
- CHK:
  - Byte == checksum -> complete the frame.
  - Otherwise -> err_checksum pulse, no cmd_valid.
  - Either way -> IDLE.
- Frame completion:
  - On the edge that consumes the final byte, register cmd_code/cmd_len/cmd_payload and assert cmd_valid.
  - The pulse is visible one cycle after the rx_data_valid cycle and lasts exactly one cycle.
  - Outputs hold their values until the next good frame; error frames never modify them.
- Timeout:
  - Counter is cleared on every rx_data_valid and held at 0 in IDLE; otherwise it increments.
  - When the counter reaches TIMEOUT_CYCLES-1 with no byte that cycle: err_timeout pulse next cycle, go to IDLE.
  - If a byte arrives in the same cycle as expiry, the byte wins: it is processed and there is no timeout.
- Error pulses and cmd_valid are mutually exclusive; at most one output pulse per cycle.
- Reset mid-frame aborts the frame without any error pulse and restores reset values.
- Widths:
  - Checksum is an 8-bit XOR.
  - The payload index counter is LEN_W bits.
  - The timeout counter is $clog2(TIMEOUT_CYCLES) bits and saturates at expiry, never wrapping.

Optional Feature:
- Macro: CMD_CHECKSUM_EN.
- Defined: the CHK state exists. Checksum byte = XOR of CMD, LEN and all payload bytes. A mismatch pulses err_checksum.
- Undefined:
  - CHK state and checksum logic are removed; err_checksum is tied to 0.
  - The frame completes on the last payload byte, or on the LEN byte when LEN=0.

Test Plan (MAX_PAYLOAD=4, CMD_CHECKSUM_EN defined unless stated):
- Bytes A5 10 02 34 12 34 -> one cmd_valid pulse one cycle after the last strobe; cmd_code=0x10, cmd_len=2, cmd_payload=0x00001234.
- Same frame with checksum byte 0x00 -> err_checksum pulse; no cmd_valid; cmd_* keep their previous values.
- Bytes A5 10 05 -> err_len pulse after the LEN byte; then A5 20 00 20 -> cmd_valid, code 0x20, len 0, payload 0.
- Bytes 00 FF 3C, then A5 11 01 A5 B5 -> leading garbage ignored; cmd_valid, code 0x11, payload 0x000000A5.
- Bytes A5 10, then silence -> err_timeout exactly TIMEOUT_CYCLES cycles after the 0x10 strobe. Repeat with a byte arriving on the expiry cycle -> no err_timeout. Then a full frame -> accepted.
- Assert rst for one cycle after A5 10 01 -> no pulses, outputs 0. Feature-off build: A5 30 01 7E -> cmd_valid on the 7E byte, payload 0x0000007E.
